// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit path: FSM state encoding and protocol constants.
package udp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CSUM,
      S_WAIT_ACK,
      S_SEND_HEAD,
      S_SEND_DATA,
      S_END
   } udp_state_e;

   localparam logic [15:0] UDP_HDR_LEN     = 16'd8;
   localparam logic [7:0]  IP_PROTO_UDP    = 8'h11;
   localparam int          MAX_LEN_DEFAULT = 1472;
   localparam logic [15:0] CSUM_LAST       = 16'd2;

endpackage

// File: rtl/udp_tx_buf.sv
// Payload buffer: simple dual-port 2^AW x 8 RAM, synchronous read with one cycle of latency.
module udp_tx_buf
   import udp_pkg::*;
#(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [7:0]    wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [7:0]    rd_data_o
);

   logic [7:0] mem_q [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      rd_data_o <= mem_q[rd_addr_i];
   end

endmodule

// File: rtl/udp_tx.sv
// UDP transmit engine: buffers one payload, builds the 8-byte header and streams it to ip_tx.
// Define UDP_TX_CHECKSUM_EN to compute the checksum; otherwise the field is sent as 16'h0000.
module udp_tx
   import udp_pkg::*;
#(
   parameter int BUF_AW  = 11,
   parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        app_wr_en,
   input  logic [7:0]  app_wr_data,
   input  logic        app_tx_start,
   input  logic [15:0] app_tx_length,
   input  logic [15:0] src_port,
   input  logic [15:0] dst_port,
   input  logic [31:0] ip_src_addr,
   input  logic [31:0] ip_dst_addr,
   output logic        udp_tx_req,
   input  logic        udp_tx_ack,
   output logic [7:0]  udp_tx_data,
   output logic        udp_tx_valid,
   output logic        udp_tx_end,
   output logic [15:0] udp_tx_length,
   output logic        udp_tx_busy,
   output logic        udp_tx_err
);

   localparam logic [15:0] MaxLen = 16'(MAX_LEN);

   udp_state_e        state_q, state_d;
   logic [15:0]       wrPtr_q, wrPtr_d, cnt_q, cnt_d, len_q, len_d;
   logic [15:0]       srcPort_q, srcPort_d, dstPort_q, dstPort_d;
   logic              ovf_q, ovf_d, err_q, err_d;
   logic              wrAccept, wrDrop, startBad, startOk;
   logic [15:0]       ptrEff, udpLen, cntInc, checksum;
   logic [BUF_AW-1:0] rdAddr;
   logic [7:0]        rdData;

   // A write arriving with app_tx_start already counts toward the length compare.
   assign wrAccept = (state_q == S_IDLE) && app_wr_en && (wrPtr_q < MaxLen);
   assign wrDrop   = (state_q == S_IDLE) && app_wr_en && (wrPtr_q >= MaxLen);
   assign ptrEff   = wrAccept ? wrPtr_q + 16'd1 : wrPtr_q;
   assign startBad = ovf_q || wrDrop || (app_tx_length > MaxLen) || (app_tx_length != ptrEff);
   assign startOk  = (state_q == S_IDLE) && app_tx_start && !startBad;
   assign udpLen   = len_q + UDP_HDR_LEN;
   assign cntInc   = cnt_q + 16'd1;

   udp_tx_buf #(.AW(BUF_AW)) u_buf (
      .clk       (clk),
      .wr_en_i   (wrAccept),
      .wr_addr_i (wrPtr_q[BUF_AW-1:0]),
      .wr_data_i (app_wr_data),
      .rd_addr_i (rdAddr),
      .rd_data_o (rdData)
   );

`ifdef UDP_TX_CHECKSUM_EN
   logic [31:0] acc_q, acc_d, pseudoSum;
   logic [31:0] srcIp_q, dstIp_q;
   logic [15:0] csumRaw;

   // Payload bytes land in the high half at even offsets, low half at odd offsets.
   always_comb begin
      pseudoSum = {16'h0, srcIp_q[31:16]} + {16'h0, srcIp_q[15:0]}
                + {16'h0, dstIp_q[31:16]} + {16'h0, dstIp_q[15:0]}
                + {24'h0, IP_PROTO_UDP} + {16'h0, udpLen} + {16'h0, udpLen}
                + {16'h0, srcPort_q} + {16'h0, dstPort_q};
      acc_d = acc_q;
      case (state_q)
         S_IDLE: begin
            if (app_tx_start && startBad) begin
               acc_d = 32'h0;
            end else if (wrAccept) begin
               acc_d = acc_q + (wrPtr_q[0] ? {24'h0, app_wr_data} : {16'h0, app_wr_data, 8'h00});
            end
         end
         S_CSUM: begin
            if (cnt_q == 16'd0) begin
               acc_d = acc_q + pseudoSum;
            end else begin
               acc_d = {16'h0, acc_q[15:0]} + {16'h0, acc_q[31:16]};
            end
         end
         S_END:   acc_d = 32'h0;
         default: acc_d = acc_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= 32'h0;
         srcIp_q <= 32'h0;
         dstIp_q <= 32'h0;
      end else begin
         acc_q <= acc_d;
         if (startOk) begin
            srcIp_q <= ip_src_addr;
            dstIp_q <= ip_dst_addr;
         end
      end
   end

   assign csumRaw  = ~acc_q[15:0];
   assign checksum = (csumRaw == 16'h0000) ? 16'hFFFF : csumRaw;
`else
   logic unusedIp;
   assign unusedIp = ^{ip_src_addr, ip_dst_addr};
   assign checksum = 16'h0000;
`endif

   always_comb begin
      state_d      = state_q;
      wrPtr_d      = wrPtr_q;
      ovf_d        = ovf_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      srcPort_d    = srcPort_q;
      dstPort_d    = dstPort_q;
      err_d        = 1'b0;
      rdAddr       = '0;
      udp_tx_req   = 1'b0;
      udp_tx_valid = 1'b0;
      udp_tx_end   = 1'b0;
      udp_tx_data  = 8'h00;
      case (state_q)
         S_IDLE: begin
            if (wrAccept) wrPtr_d = wrPtr_q + 16'd1;
            if (wrDrop)   ovf_d   = 1'b1;
            if (app_tx_start) begin
               if (startBad) begin
                  err_d   = 1'b1;
                  wrPtr_d = 16'd0;
                  ovf_d   = 1'b0;
               end else begin
                  len_d     = app_tx_length;
                  srcPort_d = src_port;
                  dstPort_d = dst_port;
                  cnt_d     = 16'd0;
                  state_d   = S_CSUM;
               end
            end
         end
         S_CSUM: begin
            cnt_d = cntInc;
            if (cnt_q == CSUM_LAST) begin
               cnt_d   = 16'd0;
               state_d = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            udp_tx_req = 1'b1;
            if (udp_tx_ack) begin
               cnt_d   = 16'd0;
               state_d = S_SEND_HEAD;
            end
         end
         S_SEND_HEAD: begin
            udp_tx_valid = 1'b1;
            case (cnt_q[2:0])
               3'd0: udp_tx_data = srcPort_q[15:8];
               3'd1: udp_tx_data = srcPort_q[7:0];
               3'd2: udp_tx_data = dstPort_q[15:8];
               3'd3: udp_tx_data = dstPort_q[7:0];
               3'd4: udp_tx_data = udpLen[15:8];
               3'd5: udp_tx_data = udpLen[7:0];
               3'd6: udp_tx_data = checksum[15:8];
               3'd7: udp_tx_data = checksum[7:0];
               default: udp_tx_data = 8'h00;
            endcase
            cnt_d = cntInc;
            // Address 0 is issued on the last header byte so payload follows without a gap.
            if (cnt_q == 16'd7) begin
               cnt_d = 16'd0;
               if (len_q == 16'd0) begin
                  udp_tx_end = 1'b1;
                  state_d    = S_END;
               end else begin
                  state_d = S_SEND_DATA;
               end
            end
         end
         S_SEND_DATA: begin
            udp_tx_valid = 1'b1;
            udp_tx_data  = rdData;
            rdAddr       = cntInc[BUF_AW-1:0];
            cnt_d        = cntInc;
            if (cnt_q == len_q - 16'd1) begin
               udp_tx_end = 1'b1;
               cnt_d      = 16'd0;
               state_d    = S_END;
            end
         end
         S_END: begin
            wrPtr_d = 16'd0;
            ovf_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         wrPtr_q   <= 16'd0;
         ovf_q     <= 1'b0;
         cnt_q     <= 16'd0;
         len_q     <= 16'd0;
         srcPort_q <= 16'd0;
         dstPort_q <= 16'd0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wrPtr_q   <= wrPtr_d;
         ovf_q     <= ovf_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         srcPort_q <= srcPort_d;
         dstPort_q <= dstPort_d;
         err_q     <= err_d;
      end
   end

   assign udp_tx_busy   = (state_q != S_IDLE);
   assign udp_tx_length = (state_q != S_IDLE) ? udpLen : 16'd0;
   assign udp_tx_err    = err_q;

endmodule
